// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx
//  Purpose  : Serial-in, parallel-out deserializer. Collects a qualified,
//             LSB-first serial stream delimited by a start-of-frame marker
//             into WIDTH-bit words. Each word is presented through a
//             one-entry valid/ready holding register. Framing aborts and
//             dropped words are reported.
//  Ports    : clk         - system clock, rising edge
//             rst         - asynchronous reset, active low
//             sin         - serial data bit
//             sin_valid   - qualifies sin (and sof)
//             sof         - start of frame, marks sin as bit 0
//             data_out    - assembled word, LSB = first received bit
//             out_valid   - data_out holds an unconsumed word
//             out_ready   - consumer accepts when out_valid & out_ready
//             busy        - frame in progress
//             frame_err   - one-cycle pulse, frame aborted by a new sof
//             overrun     - sticky, a completed word was dropped
//             clr_ovr     - synchronous clear of overrun
//             parity_err  - parity status of data_out
//  Options  : SIPO_RX_PARITY_EN - adds a trailing even-parity bit per frame
//             and drives parity_err; when undefined parity_err is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_rx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clr_ovr,
   output logic             parity_err
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SIPO_RX_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic             ferr_q,  ferr_d;
   logic             ovr_q,   ovr_d;

   // Completion strobe and the finished word, valid in the completion cycle
   logic             w_done;
   logic [WIDTH-1:0] w_word;
   logic             w_ovr_set;
`ifdef SIPO_RX_PARITY_EN
   logic             perr_q, perr_d;
   logic             w_perr;
`endif

   // ------------------------------------------------------------------------
   // Frame assembly
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      shift_d = shift_q;
      ferr_d  = 1'b0;
      w_done  = 1'b0;
      w_word  = shift_q;
`ifdef SIPO_RX_PARITY_EN
      w_perr  = 1'b0;
`endif
      if (sin_valid) begin
         if (sof) begin
            // A sof outside IDLE throws away the partial word
            ferr_d  = (state_q != ST_IDLE);
            state_d = ST_SHIFT;
            count_d = CW'(1);
            shift_d = {{(WIDTH-1){1'b0}}, sin};
         end else begin
            case (state_q)
               ST_SHIFT: begin
                  shift_d[count_q] = sin;
                  if (count_q == LAST_IDX) begin
                     count_d = '0;
`ifdef SIPO_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     // Word leaves straight from the bypass so the output
                     // register loads on this same edge
                     state_d = ST_IDLE;
                     w_done  = 1'b1;
                     w_word  = {sin, shift_q[WIDTH-2:0]};
`endif
                  end else begin
                     count_d = count_q + CW'(1);
                  end
               end
`ifdef SIPO_RX_PARITY_EN
               ST_PARITY: begin
                  state_d = ST_IDLE;
                  w_done  = 1'b1;
                  w_word  = shift_q;
                  // Even parity: data bits plus parity bit must XOR to 0
                  w_perr  = ^{shift_q, sin};
               end
`endif
               default: begin
                  // IDLE: data without sof is ignored
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output holding register and overrun tracking
   // ------------------------------------------------------------------------
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
`ifdef SIPO_RX_PARITY_EN
      perr_d    = perr_q;
`endif
      w_ovr_set = w_done & valid_q & ~out_ready;
      // A register being freed this cycle can take the new word gap-free
      if (w_done && (!valid_q || out_ready)) begin
         data_d  = w_word;
         valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
         perr_d  = w_perr;
`endif
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      // Set has priority over a simultaneous clear
      ovr_d = w_ovr_set | (ovr_q & ~clr_ovr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef SIPO_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign data_out   = data_q;
   assign out_valid  = valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
`ifdef SIPO_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
